// File: rtl/ysyx_23060096_ifu_if.sv
// ---------------------------------------------------------------------------
// ysyx_23060096_ifu_if
// Bundles the fetch unit's handshake and bus signals.
//   fetch control : fetch_en
//   imem request  : imem_req_valid, imem_req_ready, imem_req_addr
//   imem response : imem_rsp_valid, imem_rsp_data, imem_rsp_err
//   decode port   : inst_valid, inst_ready, inst, inst_pc, inst_err
//   redirect      : redirect_valid, redirect_pc
// master = fetch unit side, slave = memory/decode/execute side.
// ---------------------------------------------------------------------------
interface ysyx_23060096_ifu_if #(
  parameter int XLEN = 32
);
  logic            fetch_en;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            imem_rsp_err;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_err;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    input  fetch_en,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output inst_valid, inst, inst_pc, inst_err,
    input  inst_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    output fetch_en,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  inst_valid, inst, inst_pc, inst_err,
    output inst_ready,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ysyx_23060096_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_23060096_ifu
// Decoupled instruction fetch front end. Issues sequential in-order requests
// to instruction memory, buffers responses with their PCs in a DEPTH-entry
// FIFO and presents the FIFO head to decode. A redirect flushes the FIFO and
// marks every in-flight response to be discarded.
// Ports:
//   clk   : clock, all state on rising edge
//   rstn  : asynchronous active-low reset
//   bus   : ysyx_23060096_ifu_if.master (fetch enable, imem request and
//           response, decode valid/ready port, redirect)
// ---------------------------------------------------------------------------
module ysyx_23060096_ifu #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int              DEPTH    = 4
) (
  input logic                 clk,
  input logic                 rstn,
  ysyx_23060096_ifu_if.master bus
);
  localparam int              PW      = $clog2(DEPTH);
  localparam int              CW      = PW + 1;
  localparam logic [CW:0]     LIMIT   = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0]  r_fetch_pc;
  logic [XLEN-1:0]  r_rsp_pc;
  logic [CW-1:0]    r_outstanding;
  logic [CW-1:0]    r_drop;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [31:0]      r_inst_mem [DEPTH];
  logic [XLEN-1:0]  r_pc_mem   [DEPTH];
  logic [DEPTH-1:0] r_err_mem;

  logic            w_credit;
  logic            w_req_fire;
  logic            w_rsp_take;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_out_next;
  logic [XLEN-1:0] w_redir_pc;

  // Credit counts buffered plus in-flight entries so every response has a
  // FIFO slot; it uses registered state only, so inst_ready never reaches
  // imem_req_valid combinationally.
  assign w_credit   = ({1'b0, r_count} + {1'b0, r_outstanding}) < LIMIT;
  assign w_req_fire = bus.imem_req_valid & bus.imem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp_take = bus.imem_rsp_valid & (r_outstanding != '0);
  assign w_push     = w_rsp_take & (r_drop == '0) & ~bus.redirect_valid;
  assign w_pop      = bus.inst_valid & bus.inst_ready;
  assign w_out_next = r_outstanding + CW'(w_req_fire) - CW'(w_rsp_take);
  assign w_redir_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};

  // rstn gates the request so nothing is offered while reset is held.
  assign bus.imem_req_valid = rstn & bus.fetch_en & w_credit;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.inst_valid     = (r_count != '0);
  assign bus.inst           = r_inst_mem[r_rd_ptr];
  assign bus.inst_pc        = r_pc_mem[r_rd_ptr];
  assign bus.inst_err       = r_err_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (bus.redirect_valid) begin
        r_fetch_pc <= w_redir_pc;
        r_rsp_pc   <= w_redir_pc;
        // Everything still in flight after this edge, including a request
        // accepted in this very cycle, belongs to the old stream.
        r_drop     <= w_out_next;
        r_count    <= '0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + PC_STEP;
        if (w_push)     r_rsp_pc   <= r_rsp_pc + PC_STEP;
        if (w_rsp_take && (r_drop != '0)) r_drop <= r_drop - 1'b1;
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Storage is cleared on reset so the decode outputs read zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_inst_mem[i] <= '0;
        r_pc_mem[i]   <= '0;
      end
      r_err_mem <= '0;
    end else if (w_push) begin
      r_inst_mem[r_wr_ptr] <= bus.imem_rsp_data;
      r_pc_mem[r_wr_ptr]   <= r_rsp_pc;
      r_err_mem[r_wr_ptr]  <= bus.imem_rsp_err;
    end
  end
endmodule

// File: doc/ysyx_23060096_ifu.md
# ysyx_23060096_ifu

Parametrised instruction fetch unit replacing the single-register PC stage of the NPC with a decoupled fetch front end. It keeps a sequential fetch PC and issues in-order requests to instruction memory over a valid/ready port. Responses are buffered with their PCs in a DEPTH-entry FIFO and handed to decode over a valid/ready port. A redirect from execute flushes the FIFO and discards in-flight responses.

## Interface
- XLEN, 32, address/PC width
- RESET_PC, 32'h8000_0000, first fetch address after reset (bits [1:0] must be 0)
- DEPTH, 4, FIFO entries and max in-flight budget; power of 2, ≥2
- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- fetch_en  in  1  1 = new requests may be issued
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  request address
- imem_rsp_valid  in  1  response valid (in order, always accepted)
- imem_rsp_data  in  32  instruction word
- imem_rsp_err  in  1  access fault for this response
- inst_valid  out  1  FIFO head valid
- inst_ready  in  1  decode accepts head
- inst  out  32  head instruction
- inst_pc  out  XLEN  head PC
- inst_err  out  1  head access fault
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] forced to 0

## Operation
- State: fetch_pc, rsp_pc, outstanding (clog2(DEPTH)+1 bits), drop (same width), FIFO of {inst, pc, err} with rd/wr pointers and count.
- Credit: credit = (count + outstanding) < DEPTH, from registered values only (no inst_ready→imem_req_valid path).
- imem_req_valid = fetch_en & credit; imem_req_addr = fetch_pc.
- Request handshake (valid & ready): fetch_pc += 4 (mod 2^XLEN, wraps), outstanding += 1.
- Response (imem_rsp_valid): outstanding -= 1. If drop ≠ 0: drop -= 1, data discarded. Else push {data, rsp_pc, err}, rsp_pc += 4.
- Invariant count + outstanding ≤ DEPTH: a push never finds the FIFO full. A response with outstanding = 0 is a protocol error; ignore it.
- Pop on inst_valid & inst_ready. inst/inst_pc/inst_err show the FIFO head, stable while inst_valid & !inst_ready.
- Redirect (highest priority), at the edge:
  - count ← 0, pointers reset.
  - fetch_pc ← rsp_pc ← {redirect_pc[XLEN-1:2], 2'b00}.
  - drop ← outstanding after this cycle's request and response updates. A request accepted in the redirect cycle is included and is dropped.
  - A pop in the redirect cycle completes normally.
  - A response arriving in the redirect cycle is discarded.
- imem_req_addr may change without a handshake only on redirect.
- fetch_en = 0: no new requests; outstanding responses still complete and are pushed or dropped.
- rsp_err does not stop fetch; the fault is flagged per entry only.

## Timing
- Reset (async assert, sync use after release):
  - imem_req_valid = 0, inst_valid = 0, inst = 0, inst_pc = 0, inst_err = 0.
  - fetch_pc = rsp_pc = RESET_PC; outstanding = drop = count = 0; FIFO storage cleared.
- First cycle after rstn rises: imem_req_valid = fetch_en, addr RESET_PC.
- Response in cycle t: inst_valid = 1 in cycle t+1 at the earliest. No bypass.
- Memory responses arrive ≥1 cycle after their request handshake.
- With 1-cycle memory, DEPTH ≥ 3 sustains 1 instruction per cycle. DEPTH = 2 gives 1 per 2 cycles.
- Redirect in cycle t: inst_valid = 0 in t+1; request at redirect_pc in t+1; first new instruction at t+3 with 1-cycle memory.
- Reset mid-operation: all state returns to reset values immediately. Memory must not deliver responses to pre-reset requests after reset.

## Test plan
- Reset then fetch_en = 1, 1-cycle memory, inst_ready = 1 → requests 0x80000000, 0x80000004, 0x80000008…; inst_pc follows the same sequence, first inst_valid 2 cycles after the first request.
- inst_ready = 0, DEPTH = 4 → exactly 4 requests (0x80000000–0x8000000C), then imem_req_valid = 0. inst/inst_pc hold 0x80000000 stable. Raise inst_ready → one pop per cycle, fetch resumes at 0x80000010.
- 3-cycle memory, 2 requests in flight, redirect to 0x80000100 → both late responses discarded, FIFO empty, next request and next inst_pc = 0x80000100.
- Redirect to 0x80000203 in the same cycle request 0x80000008 is accepted → drop includes it; its response is discarded; next request and next inst_pc = 0x80000200.
- rsp_err = 1 on the response for 0x80000004 → inst_err = 1 only on that entry; 0x80000008 is delivered with inst_err = 0.
- fetch_pc = 0xFFFFFFFC, XLEN = 32 → next request 0x00000000. Assert rstn low mid-stream → outputs reach reset values immediately; after release, fetch restarts at RESET_PC.
